// File: rtl/tl_sensor_cond.sv
// Loop-detector conditioning: 2-FF sync, debounce, rising-edge events and
// per-lane saturating queue counts. Optional stale-queue timeout via TL_SENSOR_TIMEOUT_EN.
module tl_sensor_cond #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           arr_raw,
    input  logic [3:0]           dep_raw,
    output logic                 Ta,
    output logic                 Tal,
    output logic                 Tb,
    output logic                 Tbl,
    output logic [4*CNT_W-1:0]   q_cnt
);

    localparam logic [3:0]       DB_LAST = 4'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (DB_CYCLES < 1 || DB_CYCLES > 15 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_check
        $error("tl_sensor_cond: DB_CYCLES or TIMEOUT out of range");
    end

    // Bits [3:0] are arrivals, [7:4] departures, both in lane order A, A-left, B, B-left.
    logic [7:0]       s1_q, s1_d, s2_q, s2_d;
    logic [7:0]       filt_q, filt_d, filt_dly_q, filt_dly_d;
    logic [7:0]       ev_q, ev_d;
    logic [3:0]       db_cnt_q [8];
    logic [3:0]       db_cnt_d [8];
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        s1_d       = {dep_raw, arr_raw};
        s2_d       = s1_q;
        filt_d     = filt_q;
        filt_dly_d = filt_q;
        ev_d       = filt_q & ~filt_dly_q;
        for (int b = 0; b < 8; b++) begin
            db_cnt_d[b] = '0;
            if (s2_q[b] != filt_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    filt_d[b] = s2_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + 4'd1;
                end
            end
        end
    end

`ifdef TL_SENSOR_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] tmr_q [4];
    logic [15:0] tmr_d [4];
`endif

    always_comb begin
        for (int l = 0; l < 4; l++) begin
            cnt_d[l] = cnt_q[l];
            if (ev_q[l] && !ev_q[l+4] && cnt_q[l] != CNT_MAX) begin
                cnt_d[l] = cnt_q[l] + CNT_W'(1);
            end else if (ev_q[l+4] && !ev_q[l] && cnt_q[l] != '0) begin
                cnt_d[l] = cnt_q[l] - CNT_W'(1);
            end
`ifdef TL_SENSOR_TIMEOUT_EN
            // Any event restarts the idle timer and wins over a simultaneous expiry.
            tmr_d[l] = '0;
            if (!ev_q[l] && !ev_q[l+4] && cnt_q[l] != '0) begin
                if (tmr_q[l] == TMO_LAST) begin
                    cnt_d[l] = '0;
                end else begin
                    tmr_d[l] = tmr_q[l] + 16'd1;
                end
            end
`endif
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    // NOTE: the small per-bit/per-lane arrays are control state, so they are reset like any flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            filt_q     <= '0;
            filt_dly_q <= '0;
            ev_q       <= '0;
            for (int b = 0; b < 8; b++) db_cnt_q[b] <= '0;
            for (int l = 0; l < 4; l++) cnt_q[l] <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_dly_d;
            ev_q       <= ev_d;
            for (int b = 0; b < 8; b++) db_cnt_q[b] <= db_cnt_d[b];
            for (int l = 0; l < 4; l++) cnt_q[l] <= cnt_d[l];
        end
    end

`ifdef TL_SENSOR_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int l = 0; l < 4; l++) tmr_q[l] <= '0;
        end else begin
            for (int l = 0; l < 4; l++) tmr_q[l] <= tmr_d[l];
        end
    end
`else
`endif

    for (genvar l = 0; l < 4; l++) begin : g_pack
        assign q_cnt[l*CNT_W +: CNT_W] = cnt_q[l];
    end

    assign Ta  = (cnt_q[0] != '0);
    assign Tal = (cnt_q[1] != '0);
    assign Tb  = (cnt_q[2] != '0);
    assign Tbl = (cnt_q[3] != '0);

endmodule
